i2s_rx: RTL and testbench



---
 rtl/i2s_rx_if.sv | 13 +
 rtl/i2s_rx.sv | 195 +++++++++++++++++++
 tb/tb_i2s_rx.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_if.sv
// Sample-pair stream from the I2S receiver to the sound core.
// The master (receiver) drives the pair and valid; the slave (consumer) drives ready.
interface i2s_rx_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic             out_valid;
    logic             out_ready;

    modport master (output left, output right, output out_valid, input out_ready);
    modport slave  (input left, input right, input out_valid, output out_ready);
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples bclk/lrclk/sdin on clk and emits one left/right pair per frame.
// Optional slot-count checking is enabled with the macro I2S_RX_FRAMECHK_EN.
module i2s_rx #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     bclk,
    input  logic     lrclk,
    input  logic     sdin,
    i2s_rx_if.master pair,
    output logic     overrun,
    output logic     frame_err,
    input  logic     err_clr
);
    localparam logic [5:0] CNT_IDLE  = 6'd63;
    localparam logic [5:0] CNT_WIDTH = 6'(WIDTH);

    // Synchronizer chains, all three with identical latency
    logic [SYNC_STAGES-1:0] bclk_sync_d, bclk_sync_q;
    logic [SYNC_STAGES-1:0] lr_sync_d, lr_sync_q;
    logic [SYNC_STAGES-1:0] sd_sync_d, sd_sync_q;

    assign bclk_sync_d[0] = bclk;
    assign lr_sync_d[0]   = lrclk;
    assign sd_sync_d[0]   = sdin;

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign bclk_sync_d[gi] = bclk_sync_q[gi-1];
            assign lr_sync_d[gi]   = lr_sync_q[gi-1];
            assign sd_sync_d[gi]   = sd_sync_q[gi-1];
        end
    endgenerate

    // Edge-detect stage: rise_q is a registered one-cycle pulse, lr_s_q/sd_s_q are aligned with it
    logic bclk_prev_d, bclk_prev_q;
    logic rise_d, rise_q;
    logic lr_s_d, lr_s_q;
    logic sd_s_d, sd_s_q;

    assign bclk_prev_d = bclk_sync_q[SYNC_STAGES-1];
    assign rise_d      = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
    assign lr_s_d      = lr_sync_q[SYNC_STAGES-1];
    assign sd_s_d      = sd_sync_q[SYNC_STAGES-1];

    logic [WIDTH-1:0] shift_d, shift_q;
    logic [5:0]       bitcnt_d, bitcnt_q;
    logic             chan_d, chan_q;
    logic             lr_prev_d, lr_prev_q;
    logic             synced_d, synced_q;
    logic [WIDTH-1:0] left_hold_d, left_hold_q;
    logic [WIDTH-1:0] left_d, left_q;
    logic [WIDTH-1:0] right_d, right_q;
    logic             out_valid_d, out_valid_q;
    logic             overrun_d, overrun_q;
    logic             pair_done;
    logic             ovr_event;
    logic [WIDTH-1:0] word;

    // Word as it stands once the current bit is shifted in
    assign word = (shift_q << 1) | WIDTH'(sd_s_q);

    always_comb begin
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        chan_d      = chan_q;
        lr_prev_d   = lr_prev_q;
        synced_d    = synced_q;
        left_hold_d = left_hold_q;
        left_d      = left_q;
        right_d     = right_q;
        pair_done   = 1'b0;
        if (rise_q) begin
            if (lr_s_q != lr_prev_q) begin
                // Channel boundary: this rise is the delay slot
                bitcnt_d  = 6'd1;
                chan_d    = lr_s_q;
                lr_prev_d = lr_s_q;
                if (!lr_s_q) begin
                    synced_d = 1'b1;
                end
            end else begin
                if (bitcnt_q >= 6'd1 && bitcnt_q <= CNT_WIDTH) begin
                    shift_d = word;
                end
                if (bitcnt_q != CNT_IDLE) begin
                    bitcnt_d = bitcnt_q + 6'd1;
                end
                if (bitcnt_q == CNT_WIDTH) begin
                    if (!chan_q) begin
                        left_hold_d = word;
                    end else if (synced_q) begin
                        left_d    = left_hold_q;
                        right_d   = word;
                        pair_done = 1'b1;
                    end
                end
            end
        end
    end

    // A fresh pair wins over acceptance; overrun only if the old pair was not taken
    always_comb begin
        out_valid_d = out_valid_q;
        if (out_valid_q && pair.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (pair_done) begin
            out_valid_d = 1'b1;
        end
        ovr_event = pair_done && out_valid_q && !pair.out_ready;
        overrun_d = overrun_q;
        if (ovr_event) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            bclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            lr_s_q      <= 1'b0;
            sd_s_q      <= 1'b0;
            shift_q     <= '0;
            bitcnt_q    <= CNT_IDLE;
            chan_q      <= 1'b0;
            lr_prev_q   <= 1'b0;
            synced_q    <= 1'b0;
            left_hold_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            bclk_sync_q <= bclk_sync_d;
            lr_sync_q   <= lr_sync_d;
            sd_sync_q   <= sd_sync_d;
            bclk_prev_q <= bclk_prev_d;
            rise_q      <= rise_d;
            lr_s_q      <= lr_s_d;
            sd_s_q      <= sd_s_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            chan_q      <= chan_d;
            lr_prev_q   <= lr_prev_d;
            synced_q    <= synced_d;
            left_hold_q <= left_hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef I2S_RX_FRAMECHK_EN
    // bitcnt at a boundary equals the rise count of the half that just ended
    logic frame_bad;
    logic frame_err_d, frame_err_q;

    always_comb begin
        frame_bad = rise_q && (lr_s_q != lr_prev_q) && synced_q && (bitcnt_q != 6'd32);
        frame_err_d = frame_err_q;
        if (frame_bad) begin
            frame_err_d = 1'b1;
        end else if (err_clr) begin
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign pair.left      = left_q;
    assign pair.right     = right_q;
    assign pair.out_valid = out_valid_q;
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: a behavioural I2S master drives frames and a
// queue-based model predicts which sample pairs must appear and when.
module tb_i2s_rx;
    localparam int WIDTH       = 24;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 4;
`ifdef I2S_RX_FRAMECHK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, bclk, lrclk, sdin, overrun, frame_err, err_clr;

    i2s_rx_if #(.WIDTH(WIDTH)) bus ();

    i2s_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .sdin      (sdin),
        .pair      (bus),
        .overrun   (overrun),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Observer: every rising edge of out_valid records the pair and its latency
    logic [WIDTH-1:0] cap_l[$];
    logic [WIDTH-1:0] cap_r[$];
    int               cap_dt[$];
    int               lsb_cyc = 0;
    logic             ov_prev = 1'b0;
    int               hi_cnt = 0;
    int               last_hi = 0;

    always @(negedge clk) begin
        if (bus.out_valid && !ov_prev) begin
            cap_l.push_back(bus.left);
            cap_r.push_back(bus.right);
            cap_dt.push_back(cyc - lsb_cyc);
        end
        if (bus.out_valid) begin
            hi_cnt++;
        end else if (hi_cnt > 0) begin
            last_hi = hi_cnt;
            hi_cnt  = 0;
        end
        ov_prev = bus.out_valid;
    end

    task automatic clear_caps();
        cap_l.delete();
        cap_r.delete();
        cap_dt.delete();
    endtask

    // One bclk slot: data/lrclk change on the falling edge, receiver samples on the rising edge
    task automatic slot(input logic lr, input logic b, input bit mark);
        @(negedge clk);
        bclk  = 1'b0;
        lrclk = lr;
        sdin  = b;
        repeat (HALF) @(negedge clk);
        bclk = 1'b1;
        if (mark) lsb_cyc = cyc;
        repeat (HALF - 1) @(negedge clk);
    endtask

    task automatic send_half(input logic lr, input logic [WIDTH-1:0] w, input int nslots,
                             input int first, input int rst_slot);
        logic b;
        for (int i = first; i < nslots; i++) begin
            if (i == rst_slot) begin
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            if (i >= 1 && i <= WIDTH) b = w[WIDTH-i];
            else b = 1'($urandom);
            slot(lr, b, lr && (i == WIDTH));
        end
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        send_half(1'b0, l, 32, 0, -1);
        send_half(1'b1, r, 32, 0, -1);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [WIDTH-1:0] exp_l[$];
    logic [WIDTH-1:0] exp_r[$];

    initial begin
        rst_n = 1'b0; bclk = 1'b0; lrclk = 1'b0; sdin = 1'b0; err_clr = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_left", 32'(bus.left), 32'h0);
        check_val("rst_right", 32'(bus.right), 32'h0);
        check_val("rst_valid", 32'(bus.out_valid), 32'h0);
        check_val("rst_overrun", 32'(overrun), 32'h0);
        check_val("rst_frame_err", 32'(frame_err), 32'h0);

        // bclk toggling under reset for 200 clk
        for (int i = 0; i < 25; i++) slot(1'($urandom), 1'($urandom), 1'b0);
        slot(1'b0, 1'b0, 1'b0);
        check_val("rst_hold_pairs", 32'(cap_l.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // Partial first frame (starts mid-left) is discarded, next full frame is emitted
        send_half(1'b0, 24'h123456, 32, 16, -1);
        send_half(1'b1, 24'hABCDEF, 32, 0, -1);
        check_val("partial_no_pair", 32'(cap_l.size()), 32'd0);
        send_frame(24'h123456, 24'hABCDEF);
        check_val("first_pair_count", 32'(cap_l.size()), 32'd1);
        if (cap_l.size() == 1) begin
            check_val("first_left", 32'(cap_l[0]), 32'h123456);
            check_val("first_right", 32'(cap_r[0]), 32'hABCDEF);
            check_val("first_latency", 32'(cap_dt[0]), 32'(SYNC_STAGES + 2));
        end
        check_val("valid_pulse_len", 32'(last_hi), 32'd1);

        // Consumer stalled: second pair overwrites the first
        @(negedge clk);
        bus.out_ready = 1'b0;
        clear_caps();
        send_frame(24'h000001, 24'h800000);
        send_frame(24'h7FFFFF, 24'hFFFFFF);
        check_val("ovr_left", 32'(bus.left), 32'h7FFFFF);
        check_val("ovr_right", 32'(bus.right), 32'hFFFFFF);
        check_val("ovr_valid", 32'(bus.out_valid), 32'h1);
        check_val("ovr_flag", 32'(overrun), 32'h1);
        check_val("ovr_rises", 32'(cap_l.size()), 32'd1);
        pulse_err_clr();
        check_val("clr_overrun", 32'(overrun), 32'h0);
        check_val("clr_valid_kept", 32'(bus.out_valid), 32'h1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val("accept_valid", 32'(bus.out_valid), 32'h0);
        check_val("accept_left_hold", 32'(bus.left), 32'h7FFFFF);
        check_val("no_frame_err_yet", 32'(frame_err), 32'h0);

        // Reset pulse in the middle of the right channel
        bus.out_ready = 1'b1;
        clear_caps();
        send_half(1'b0, 24'h111111, 32, 0, -1);
        send_half(1'b1, 24'h222222, 32, 0, 10);
        send_frame(24'h0F0F0F, 24'hF0F0F0);
        check_val("midrst_pairs", 32'(cap_l.size()), 32'd1);
        if (cap_l.size() == 1) begin
            check_val("midrst_left", 32'(cap_l[0]), 32'h0F0F0F);
            check_val("midrst_right", 32'(cap_r[0]), 32'hF0F0F0);
        end

        // Short left half (31 slots)
        clear_caps();
        send_half(1'b0, 24'h135790, 31, 0, -1);
        send_half(1'b1, 24'h2468AC, 32, 0, -1);
        send_frame(24'h0A0B0C, 24'h0D0E0F);
        check_val("short_frame_err", 32'(frame_err), 32'(FCHK));
        check_val("short_pairs", 32'(cap_l.size()), 32'd2);
        if (cap_l.size() == 2) begin
            check_val("short_left0", 32'(cap_l[0]), 32'h135790);
            check_val("short_right0", 32'(cap_r[0]), 32'h2468AC);
            check_val("short_left1", 32'(cap_l[1]), 32'h0A0B0C);
            check_val("short_right1", 32'(cap_r[1]), 32'h0D0E0F);
        end
        pulse_err_clr();
        check_val("clr_frame_err", 32'(frame_err), 32'h0);

        // Random frames against the model: each full frame yields exactly its pair
        clear_caps();
        exp_l.delete();
        exp_r.delete();
        for (int f = 0; f < 6; f++) begin
            logic [WIDTH-1:0] wl, wr;
            wl = WIDTH'($urandom);
            wr = WIDTH'($urandom);
            exp_l.push_back(wl);
            exp_r.push_back(wr);
            send_frame(wl, wr);
        end
        check_val("rand_pairs", 32'(cap_l.size()), 32'(exp_l.size()));
        for (int f = 0; f < exp_l.size() && f < cap_l.size(); f++) begin
            check_val($sformatf("rand_left%0d", f), 32'(cap_l[f]), 32'(exp_l[f]));
            check_val($sformatf("rand_right%0d", f), 32'(cap_r[f]), 32'(exp_r[f]));
            check_val($sformatf("rand_lat%0d", f), 32'(cap_dt[f]), 32'(SYNC_STAGES + 2));
        end
        check_val("rand_overrun", 32'(overrun), 32'h0);

        // lrclk stuck high: counter saturates, nothing emitted, no error
        clear_caps();
        for (int i = 0; i < 80; i++) slot(1'b1, 1'($urandom), 1'b0);
        check_val("stuck_pairs", 32'(cap_l.size()), 32'd0);
        check_val("stuck_valid", 32'(bus.out_valid), 32'h0);
        check_val("stuck_frame_err", 32'(frame_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
